// File: rtl/timer_in_cond.sv
// Input conditioner for the general timer: 2-flop synchroniser, glitch filter, clean level, edge strobe.
// Optional glitch counter (glitch_clr_i / glitch_cnt_o) is built when TIMER_IN_GLITCH_CNT_EN is defined.
module timer_in_cond #(
    parameter int FILT_W = 8
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              raw_i,
    input  logic              en_i,
    input  logic [FILT_W-1:0] filt_len_i,
    input  logic [1:0]        edge_sel_i,
`ifdef TIMER_IN_GLITCH_CNT_EN
    input  logic              glitch_clr_i,
    output logic [15:0]       glitch_cnt_o,
`endif
    output logic              level_o,
    output logic              pulse_o
);

    localparam logic [FILT_W-1:0] CNT_ONE = {{(FILT_W-1){1'b0}}, 1'b1};

    logic              s1_q, s1_d;
    logic              s2_q, s2_d;
    logic              lvl_q, lvl_d;
    logic [FILT_W-1:0] cnt_q, cnt_d;
    logic              pulse_q, pulse_d;
    logic              accept;

    // Synchroniser stages are plain copies so nothing sits between the two flops.
    always_comb begin
        s1_d = raw_i;
        s2_d = s1_q;
    end

    always_comb begin
        lvl_d   = lvl_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        pulse_d = 1'b0;
        if (!en_i) begin
            lvl_d = s2_q;
            cnt_d = '0;
        end else if (s2_q == lvl_q) begin
            cnt_d = '0;
        end else if (cnt_q >= filt_len_i) begin
            // >= so a shortened filter length accepts an overdue count at once
            lvl_d  = s2_q;
            cnt_d  = '0;
            accept = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
        pulse_d = accept && (s2_q ? edge_sel_i[0] : edge_sel_i[1]);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            lvl_q   <= 1'b0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            lvl_q   <= lvl_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign level_o = lvl_q;
    assign pulse_o = pulse_q;

`ifdef TIMER_IN_GLITCH_CNT_EN
    logic        glitch_evt;
    logic [15:0] gcnt_q, gcnt_d;

    // A partial count collapsing back to the held level is a rejected glitch.
    always_comb begin
        glitch_evt = en_i && (s2_q == lvl_q) && (cnt_q != '0);
        gcnt_d     = gcnt_q;
        if (glitch_clr_i) begin
            gcnt_d = '0;
        end else if (glitch_evt && (gcnt_q != 16'hFFFF)) begin
            gcnt_d = gcnt_q + 16'd1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            gcnt_q <= '0;
        end else begin
            gcnt_q <= gcnt_d;
        end
    end

    assign glitch_cnt_o = gcnt_q;
`endif

endmodule

// File: tb/tb_timer_in_cond.sv
// Directed bench for timer_in_cond: latency table, edge-select table and hand-written corner sequences.
module tb_timer_in_cond;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, raw, en;
    logic [7:0] flen;
    logic [1:0] esel;
    logic       level, pulse;
`ifdef TIMER_IN_GLITCH_CNT_EN
    logic        gclr;
    logic [15:0] gcnt;
`endif

    timer_in_cond #(.FILT_W(8)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .raw_i       (raw),
        .en_i        (en),
        .filt_len_i  (flen),
        .edge_sel_i  (esel),
`ifdef TIMER_IN_GLITCH_CNT_EN
        .glitch_clr_i(gclr),
        .glitch_cnt_o(gcnt),
`endif
        .level_o     (level),
        .pulse_o     (pulse)
    );

    typedef struct {
        logic [7:0] n;
        logic [1:0] esel;
        int         rise_e;
        logic       rise_p;
        int         fall_e;
        logic       fall_p;
    } lat_t;

    typedef struct {
        logic [1:0] esel;
        int         pulses;
    } es_t;

    int   tests = 0, fails = 0;
    int   pcnt = 0, adj = 0, dly_err = 0;
    logic prev_p = 1'b0, lvl_seen = 1'b0, dly_on = 1'b0;
    logic [2:0] hist = 3'b000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock per iteration; outputs are sampled 1ns after the rising edge.
    task automatic step(input int n);
        repeat (n) begin
            hist = {hist[1:0], raw};
            @(posedge clk);
            #1;
            if (pulse === 1'b1) begin
                pcnt++;
                if (prev_p) adj++;
            end
            prev_p = pulse;
            if (level === 1'b1) lvl_seen = 1'b1;
            if (dly_on && (level !== hist[2])) dly_err++;
        end
    endtask

    // e = index of the edge (E0 = first edge) at which level reaches v, -1 on timeout.
    task automatic wait_lvl(input logic v, input int budget, output int e, output logic p);
        e = -1;
        p = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step(1);
            if (level === v) begin
                e = i;
                p = pulse;
                break;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        lat_t tbl[5];
        es_t  es[4];
        int   e, p0, a0;
        logic p;

        tbl[0] = '{8'd4,   2'b11, 6,   1'b1, 6,   1'b1};
        tbl[1] = '{8'd0,   2'b01, 2,   1'b1, 2,   1'b0};
        tbl[2] = '{8'd1,   2'b10, 3,   1'b0, 3,   1'b1};
        tbl[3] = '{8'd7,   2'b00, 9,   1'b0, 9,   1'b0};
        tbl[4] = '{8'd255, 2'b01, 257, 1'b1, 257, 1'b0};
        es[0]  = '{2'b01, 4};
        es[1]  = '{2'b10, 4};
        es[2]  = '{2'b11, 8};
        es[3]  = '{2'b00, 0};

        rst = 1'b1; raw = 1'b1; en = 1'b1; flen = 8'd3; esel = 2'b01;
`ifdef TIMER_IN_GLITCH_CNT_EN
        gclr = 1'b0;
`endif
        #1;
        // reset with pin high: outputs held low
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("rst_level", level, 1'b0);
            chk("rst_pulse", pulse, 1'b0);
        end
`ifdef TIMER_IN_GLITCH_CNT_EN
        chk("rst_gcnt", gcnt, 16'd0);
`endif
        rst = 1'b0;
        wait_lvl(1'b1, 20, e, p);
        chk("post_rst_rise_edge", e, 5);
        chk("post_rst_pulse", p, 1'b1);
        step(3);
        chk("post_rst_pulse_cnt", pcnt, 1);

        raw = 1'b0; esel = 2'b00;
        wait_lvl(1'b0, 20, e, p);
        step(3);

        // latency table: rise then fall for each filter length / edge select
        for (int i = 0; i < 5; i++) begin
            flen = tbl[i].n; esel = tbl[i].esel; p0 = pcnt;
            raw = 1'b1;
            wait_lvl(1'b1, 300, e, p);
            chk("rise_edge", e, tbl[i].rise_e);
            chk("rise_pulse", p, tbl[i].rise_p);
            step(20);
            raw = 1'b0;
            wait_lvl(1'b0, 300, e, p);
            chk("fall_edge", e, tbl[i].fall_e);
            chk("fall_pulse", p, tbl[i].fall_p);
            step(4);
            chk("lat_pulse_cnt", pcnt - p0, int'(tbl[i].rise_p) + int'(tbl[i].fall_p));
        end

        // glitch rejection: 3-cycle highs never get through N=4
        flen = 8'd4; esel = 2'b11; p0 = pcnt; lvl_seen = 1'b0;
        repeat (10) begin
            raw = 1'b1; step(3);
            raw = 1'b0; step(8);
        end
        chk("glitch_level", lvl_seen, 1'b0);
        chk("glitch_pulses", pcnt - p0, 0);
`ifdef TIMER_IN_GLITCH_CNT_EN
        chk("glitch_cnt10", gcnt, 16'd10);
        gclr = 1'b1;
        raw = 1'b1; step(3);
        raw = 1'b0; step(3);
        gclr = 1'b0;
        step(2);
        chk("glitch_clr_wins", gcnt, 16'd0);
        raw = 1'b1; step(3);
        raw = 1'b0; step(6);
        chk("glitch_cnt1", gcnt, 16'd1);
`endif

        // edge select with N=0 square wave, level tracks pin 2 cycles late
        flen = 8'd0;
        for (int k = 0; k < 4; k++) begin
            esel = es[k].esel; p0 = pcnt; dly_err = 0; dly_on = 1'b1;
            repeat (4) begin
                raw = 1'b1; step(4);
                raw = 1'b0; step(4);
            end
            step(4);
            dly_on = 1'b0;
            chk("esel_pulses", pcnt - p0, es[k].pulses);
            chk("esel_delay", dly_err, 0);
        end

        // N=0, one-cycle pin pulse, both edges: two adjacent strobes
        esel = 2'b11; p0 = pcnt; a0 = adj;
        raw = 1'b1; step(1);
        raw = 1'b0; step(5);
        chk("n0_pulses", pcnt - p0, 2);
        chk("n0_adjacent", adj - a0, 1);

        // disabled: unfiltered tracking, no strobes, no glitch events
        en = 1'b0; flen = 8'd4; p0 = pcnt; dly_err = 0; dly_on = 1'b1;
        raw = 1'b1; step(1);
        raw = 1'b0; step(2);
        raw = 1'b1; step(3);
        raw = 1'b0; step(1);
        raw = 1'b1; step(5);
        dly_on = 1'b0;
        chk("dis_delay", dly_err, 0);
        chk("dis_pulses", pcnt - p0, 0);
        chk("dis_level", level, 1'b1);
`ifdef TIMER_IN_GLITCH_CNT_EN
        chk("dis_no_glitch", gcnt, 16'd1);
`endif
        en = 1'b1; step(10);
        chk("enable_no_pulse", pcnt - p0, 0);
        chk("enable_level", level, 1'b1);

        // filter length shortened mid-count accepts on the next edge
        flen = 8'd200; esel = 2'b11; p0 = pcnt;
        raw = 1'b0;
        step(52);
        chk("len_hold", level, 1'b1);
        flen = 8'd10;
        wait_lvl(1'b0, 5, e, p);
        chk("len_change_edge", e, 0);
        chk("len_change_pulse", p, 1'b1);
        step(3);
        chk("len_change_cnt", pcnt - p0, 1);

        // reset mid-count discards the pending change
        flen = 8'd100; esel = 2'b01;
        raw = 1'b1;
        step(41);
        rst = 1'b1;
        step(2);
        chk("midrst_level", level, 1'b0);
        rst = 1'b0;
        wait_lvl(1'b1, 200, e, p);
        chk("midrst_edge", e, 102);
        chk("midrst_pulse", p, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/timer_in_cond.md
# timer_in_cond

Input conditioning stage that sits directly upstream of the general timer's `capture_i` and `ext_meas_i` inputs. It does four things to an asynchronous pin:
- synchronises it into the `wb_clk_i` domain;
- rejects glitches shorter than a programmable length;
- presents a clean filtered level;
- emits a single-cycle pulse on a selectable edge.

The timer consumes `level_o` (measurement input) and `pulse_o` (capture strobe) without any further synchronisation.

## Interface
Parameters:
- `FILT_W`, default 8: width of the filter length and the filter counter.

Ports:
- `wb_clk_i`  in  1  single clock for all logic.
- `wb_rst_i`  in  1  synchronous, active-high reset.
- `raw_i`  in  1  asynchronous external pin.
- `en_i`  in  1  filter/edge-detect enable.
- `filt_len_i`  in  FILT_W  filter length N. A change is accepted after N+1 consecutive mismatching synchronised samples.
- `edge_sel_i`  in  2  pulse edge select: 00 none, 01 rising, 10 falling, 11 both.
- `glitch_clr_i`  in  1  clears the glitch counter (only when `TIMER_IN_GLITCH_CNT_EN` is defined).
- `level_o`  out  1  filtered level.
- `pulse_o`  out  1  one-cycle strobe on the selected edge of `level_o`.
- `glitch_cnt_o`  out  16  count of rejected glitches (only when `TIMER_IN_GLITCH_CNT_EN` is defined).

## Operation
- **Synchroniser:** two flops, `s1 <= raw_i` then `s2 <= s1`. No logic between the two flops.
- **Filter state:** `lvl` (drives `level_o`) and the counter `cnt[FILT_W-1:0]`. Evaluated every cycle, in priority order:
  - `en_i`=0: `lvl <= s2`, `cnt <= 0`, no pulse. Tracks the pin with no filtering and no strobes, so enabling never produces a spurious pulse.
  - `s2 == lvl`: `cnt <= 0`. If `cnt != 0` this cycle, a glitch was rejected and the glitch event fires.
  - `s2 != lvl` and `cnt >= filt_len_i`: `lvl <= s2`, `cnt <= 0`. This is the accept event.
  - `s2 != lvl` otherwise: `cnt <= cnt + 1`. The counter cannot wrap, because acceptance occurs at `cnt == filt_len_i` ≤ 2^FILT_W−1.
- **Changing `filt_len_i` mid-count:** takes effect immediately. Because of the `>=` comparison, a count already beyond the new value accepts on the next mismatching cycle.
- **Edge pulse:** `pulse_o` is registered. It is 1 for exactly the cycle following an accept event when the new `lvl` matches `edge_sel_i` (0→1 for rising, 1→0 for falling, either for 11). Otherwise it is 0.
- **Minimum pulse spacing:** back-to-back accept events are at least N+1 cycles apart, so pulses are never adjacent unless N=0. With N=0 a 1-cycle-wide input pulse yields two adjacent strobes when `edge_sel_i`=11.
- **Reset:** all state is cleared; see Timing for reset values.
  - Reset mid-count discards the pending change.
  - After reset, a pin held high is accepted through the normal filter path (`en_i`=1), which produces a rising pulse if enabled.

## Timing
- Reset values:
  - `s1`, `s2`, `lvl`, `level_o`: 0.
  - `cnt`: 0.
  - `pulse_o`: 0.
  - `glitch_cnt_o`: 0.
- Latency with `en_i`=1 and the pin changing before rising edge E0 and held stable:
  - `s2` changes at E1.
  - `level_o` changes at edge E(2+N).
  - `pulse_o` is high during the cycle following E(2+N), together with the new `level_o`.
- Rejection rule (N≥1): a pin change lasting ≤ N synchronised cycles never alters `level_o`.
- Latency with `en_i`=0: `level_o` follows the pin at E2 and `pulse_o` stays 0.
- `en_i`, `filt_len_i` and `edge_sel_i` are sampled every edge. There is no handshake.

## Configuration
- Macro: `TIMER_IN_GLITCH_CNT_EN`.
- When defined:
  - `glitch_cnt_o` and `glitch_clr_i` exist.
  - The 16-bit counter increments by 1 on each glitch event and saturates at 16'hFFFF.
  - `glitch_clr_i` zeroes it on the next edge and wins over a simultaneous glitch event.
  - `en_i`=0 produces no glitch events.
- When undefined: the ports and the counter are absent. Filter, level and pulse behaviour are identical in both builds.

## Test plan
- **Reset/default:** hold `wb_rst_i` 5 cycles with `raw_i`=1 → during reset all outputs 0. With N=3, `en_i`=1, `edge_sel_i`=01 after release: `level_o` rises at the 5th edge after release and `pulse_o` is high for exactly 1 cycle.
- **Filter acceptance:** N=4, `edge_sel_i`=11, `raw_i` 0→1 held for 20 cycles, then back to 0 → `level_o` rises 6 edges after the input change and falls 6 edges after the return. Exactly two 1-cycle pulses.
- **Glitch rejection:** N=4, `raw_i` high for 3 cycles, 10 times →
  - `level_o` stays 0 and `pulse_o` never asserts;
  - with the macro defined, `glitch_cnt_o`=10;
  - pulsing `glitch_clr_i` together with an 11th glitch → `glitch_cnt_o`=0.
- **Edge select:** N=0, square wave of period 8 for 4 periods →
  - 01 gives 4 pulses;
  - 10 gives 4 pulses;
  - 11 gives 8 pulses;
  - 00 gives 0 pulses;
  - `level_o` matches the input delayed by 2 cycles.
- **Enable and filter-length change:**
  - `en_i`=0 while toggling `raw_i` → `level_o` follows with 2-cycle delay and there are no pulses.
  - Set `en_i`=1 at `level_o`=1 → no pulse.
  - N=200, drive a change, then after 50 cycles set N=10 → accept on the next edge and one pulse.
- **Reset mid-count:** N=100, change `raw_i`, assert reset after 40 cycles → `level_o`=0 and `cnt` restarts. The change is accepted only 102 edges after release.
